// File: rtl/tx_link_seq.sv
// Transmit-side link sequencer: electrical idle, K28.5 training burst, then data
// with periodic K28.5 skip insertion and K28.5 filler on empty cycles.
module tx_link_seq #(
    parameter int unsigned IDLE_CYCLES   = 8,
    parameter int unsigned N_COMMA       = 4,
    parameter int unsigned SKIP_INTERVAL = 32,
    parameter logic [7:0]  K285          = 8'hBC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] dataS_cfg,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [7:0] dataOut8,
    output logic       K,
    output logic       TxElecIdle,
    output logic [1:0] dataS,
    output logic       link_up,
    output logic [2:0] state
);

    localparam int unsigned CNT_MAX = (IDLE_CYCLES > N_COMMA) ? IDLE_CYCLES : N_COMMA;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned BCNT_W  = $clog2(SKIP_INTERVAL);

    localparam logic [CNT_W-1:0]  IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TRAIN_LAST = CNT_W'(N_COMMA - 1);
    localparam logic [BCNT_W-1:0] SKIP_LAST  = BCNT_W'(SKIP_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ELEC_IDLE = 3'd1,
        TRAIN     = 3'd2,
        DATA      = 3'd3,
        COMMA     = 3'd4
    } state_t;

    state_t              stateCur, stateNext;
    logic [CNT_W-1:0]    cnt, cntNext;
    logic [BCNT_W-1:0]   bcnt, bcntNext;
    logic [1:0]          dataSNext;
    logic [7:0]          dataOutNext;
    logic                kNext, elecIdleNext, linkNext;
    logic                transfer;

    assign state      = stateCur;
    assign data_ready = (stateCur == DATA) & enb & ~stop;
    assign transfer   = data_valid & data_ready;

    always_comb begin
        stateNext = stateCur;
        cntNext   = cnt;
        bcntNext  = bcnt;
        dataSNext = dataS;
        if (stop) begin
            stateNext = IDLE;
            cntNext   = '0;
            bcntNext  = '0;
        end else begin
            case (stateCur)
                IDLE: begin
                    if (start) begin
                        dataSNext = (dataS_cfg == 2'b11) ? 2'b00 : dataS_cfg;
                        cntNext   = '0;
                        stateNext = ELEC_IDLE;
                    end
                end
                ELEC_IDLE: begin
                    if (cnt == IDLE_LAST) begin
                        cntNext   = '0;
                        stateNext = TRAIN;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                TRAIN: begin
                    if (cnt == TRAIN_LAST) begin
                        cntNext   = '0;
                        stateNext = DATA;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    // Only accepted bytes advance toward the next skip symbol.
                    if (transfer) begin
                        if (bcnt == SKIP_LAST) begin
                            bcntNext  = '0;
                            stateNext = COMMA;
                        end else begin
                            bcntNext = bcnt + BCNT_W'(1);
                        end
                    end
                end
                COMMA:   stateNext = DATA;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        dataOutNext  = 8'h00;
        kNext        = 1'b0;
        elecIdleNext = 1'b1;
        linkNext     = 1'b0;
        case (stateCur)
            TRAIN, COMMA: begin
                dataOutNext  = K285;
                kNext        = 1'b1;
                elecIdleNext = 1'b0;
                linkNext     = (stateCur == COMMA);
            end
            DATA: begin
                elecIdleNext = 1'b0;
                linkNext     = 1'b1;
                dataOutNext  = transfer ? data_in : K285;
                kNext        = ~transfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateCur   <= IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            dataOut8   <= 8'h00;
            K          <= 1'b0;
            TxElecIdle <= 1'b1;
            dataS      <= 2'b00;
            link_up    <= 1'b0;
        end else if (enb) begin
            stateCur   <= stateNext;
            cnt        <= cntNext;
            bcnt       <= bcntNext;
            dataOut8   <= dataOutNext;
            K          <= kNext;
            TxElecIdle <= elecIdleNext;
            dataS      <= dataSNext;
            link_up    <= linkNext;
        end
    end

endmodule

// File: tb/tb_tx_link_seq.sv
// Bench for tx_link_seq: directed bring-up/skip/filler/freeze/stop scenarios plus
// randomized traffic, all compared cycle by cycle against a countdown-based model.
module tb_tx_link_seq;

    localparam int unsigned IDLE_CYCLES   = 8;
    localparam int unsigned N_COMMA       = 4;
    localparam int unsigned SKIP_INTERVAL = 32;
    localparam logic [7:0]  K285          = 8'hBC;

    logic       clk = 1'b0;
    logic       rst, enb, start, stop, data_valid;
    logic [1:0] dataS_cfg;
    logic [7:0] data_in;
    logic       data_ready, K, TxElecIdle, link_up;
    logic [7:0] dataOut8;
    logic [1:0] dataS;
    logic [2:0] state;

    always #5 clk = ~clk;

    tx_link_seq #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .N_COMMA      (N_COMMA),
        .SKIP_INTERVAL(SKIP_INTERVAL),
        .K285         (K285)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .start     (start),
        .stop      (stop),
        .dataS_cfg (dataS_cfg),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .dataOut8  (dataOut8),
        .K         (K),
        .TxElecIdle(TxElecIdle),
        .dataS     (dataS),
        .link_up   (link_up),
        .state     (state)
    );

    int unsigned nVec = 0;
    int unsigned nErr = 0;

    // Reference model: phase number plus cycles left in the phase and bytes since last skip.
    int         mPhase = 0;
    int         mLeft  = 0;
    int         mSent  = 0;
    logic [1:0] mDataS = 2'b00;
    logic [7:0] eOut   = 8'h00;
    logic       eK     = 1'b0;
    logic       eIdle  = 1'b1;
    logic       eLink  = 1'b0;
    bit         mKnown = 1'b0;
    logic [7:0] byteCnt = 8'h00;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic st, input logic sp,
                        input logic [1:0] cfg, input logic v, input logic [7:0] d);
        logic ready, xfer;
        rst = r; enb = e; start = st; stop = sp;
        dataS_cfg = cfg; data_valid = v; data_in = d;
        #1;
        ready = (mPhase == 3) && e && !sp;
        if (mKnown) checkVal("data_ready", {31'b0, data_ready}, {31'b0, ready});
        @(posedge clk);
        xfer = ready && v;
        if (r) begin
            mPhase = 0; mLeft = 0; mSent = 0; mDataS = 2'b00;
            eOut = 8'h00; eK = 1'b0; eIdle = 1'b1; eLink = 1'b0;
            mKnown = 1'b1;
        end else if (e && mKnown) begin
            case (mPhase)
                2, 4: begin eOut = K285; eK = 1'b1; eIdle = 1'b0; end
                3: begin
                    eOut  = xfer ? d : K285;
                    eK    = !xfer;
                    eIdle = 1'b0;
                end
                default: begin eOut = 8'h00; eK = 1'b0; eIdle = 1'b1; end
            endcase
            eLink = (mPhase == 3) || (mPhase == 4);
            if (sp) begin
                mPhase = 0; mSent = 0;
            end else begin
                case (mPhase)
                    0: if (st) begin
                        mPhase = 1;
                        mLeft  = IDLE_CYCLES;
                        mDataS = (cfg == 2'b11) ? 2'b00 : cfg;
                    end
                    1: begin
                        mLeft--;
                        if (mLeft == 0) begin mPhase = 2; mLeft = N_COMMA; end
                    end
                    2: begin
                        mLeft--;
                        if (mLeft == 0) mPhase = 3;
                    end
                    3: if (xfer) begin
                        mSent++;
                        if (mSent == SKIP_INTERVAL) begin mSent = 0; mPhase = 4; end
                    end
                    default: mPhase = 3;
                endcase
            end
        end
        #1;
        if (mKnown) begin
            checkVal("state",      {29'b0, state},      32'(mPhase));
            checkVal("dataOut8",   {24'b0, dataOut8},   {24'b0, eOut});
            checkVal("K",          {31'b0, K},          {31'b0, eK});
            checkVal("TxElecIdle", {31'b0, TxElecIdle}, {31'b0, eIdle});
            checkVal("dataS",      {30'b0, dataS},      {30'b0, mDataS});
            checkVal("link_up",    {31'b0, link_up},    {31'b0, eLink});
        end
        if (xfer) byteCnt++;
    endtask

    int firstElec, firstTrain, firstData, firstIdleLow, firstLink;

    initial begin
        rst = 1'b1; enb = 1'b1; start = 1'b0; stop = 1'b0;
        dataS_cfg = 2'b00; data_valid = 1'b0; data_in = 8'h00;

        step(1, 1, 0, 0, 2'b00, 0, 8'h00);
        step(1, 1, 0, 0, 2'b00, 0, 8'h00);

        // Bring-up with start on edge 0; cycle n is what is observed after edge n-1.
        firstElec = 0; firstTrain = 0; firstData = 0; firstIdleLow = 0; firstLink = 0;
        for (int n = 0; n < 100; n++) begin
            step(0, 1, n == 0, 0, 2'b01, 1, byteCnt);
            if (firstElec == 0 && state == 3'd1) firstElec = n + 1;
            if (firstTrain == 0 && state == 3'd2) firstTrain = n + 1;
            if (firstData == 0 && state == 3'd3) firstData = n + 1;
            if (firstIdleLow == 0 && TxElecIdle === 1'b0) firstIdleLow = n + 1;
            if (firstLink == 0 && link_up === 1'b1) firstLink = n + 1;
        end
        checkVal("first_elec_idle", 32'(firstElec), 32'd1);
        checkVal("first_train", 32'(firstTrain), 32'd9);
        checkVal("first_data", 32'(firstData), 32'd13);
        checkVal("txelecidle_fall", 32'(firstIdleLow), 32'd10);
        checkVal("link_up_rise", 32'(firstLink), 32'd14);

        // Filler gap mid-stream.
        for (int n = 0; n < 5; n++) step(0, 1, 0, 0, 2'b01, 0, 8'h55);
        for (int n = 0; n < 40; n++) step(0, 1, 0, 0, 2'b01, 1, byteCnt);

        // Stop, restart with cfg 11, freeze for 4 cycles inside TRAIN.
        step(0, 1, 0, 1, 2'b01, 1, byteCnt);
        step(0, 1, 0, 0, 2'b01, 0, 8'h00);
        step(0, 1, 1, 0, 2'b11, 0, 8'h00);
        for (int n = 0; n < IDLE_CYCLES + 1; n++) step(0, 1, 0, 0, 2'b11, 1, byteCnt);
        for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 2'b11, 1, byteCnt);
        for (int n = 0; n < 10; n++) step(0, 1, 0, 0, 2'b11, 1, byteCnt);

        // Start together with stop in IDLE, then start asserted while in DATA.
        step(0, 1, 0, 1, 2'b00, 0, 8'h00);
        step(0, 1, 1, 1, 2'b10, 0, 8'h00);
        step(0, 1, 1, 0, 2'b10, 0, 8'h00);
        for (int n = 0; n < 20; n++) step(0, 1, 0, 0, 2'b10, 1, byteCnt);
        for (int n = 0; n < 5; n++) step(0, 1, 1, 0, 2'b01, 1, byteCnt);

        // Reset in the middle of ELEC_IDLE.
        step(0, 1, 0, 1, 2'b00, 0, 8'h00);
        step(0, 1, 1, 0, 2'b10, 0, 8'h00);
        for (int n = 0; n < 3; n++) step(0, 1, 0, 0, 2'b10, 0, 8'h00);
        step(1, 1, 0, 0, 2'b10, 0, 8'h00);
        for (int n = 0; n < 3; n++) step(0, 1, 0, 0, 2'b10, 0, 8'h00);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 149) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
